seq_shift_sub_divider: RTL and testbench

//   Sequential restoring divider (shift-subtract), one quotient bit per clock.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_trial_sub.sv | 22 ++
 rtl/seq_shift_sub_divider.sv | 200 ++++++++++++++++++++
 tb/tb_seq_shift_sub_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential shift-subtract divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // Counter width able to hold the value `width`.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtract for one restoring-division step: shifted remainder minus divisor.
module div_trial_sub
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r_shifted,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] difference_c,
  output logic             borrow_c
);

  logic [WIDTH:0] d_ext;

  // Compare and subtract at WIDTH+1 bits; on no-borrow the result fits WIDTH bits.
  always_comb begin
    d_ext        = {1'b0, d};
    borrow_c     = (r_shifted < d_ext);
    difference_c = WIDTH'(r_shifted - d_ext);
  end

endmodule

// File: rtl/seq_shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per clock, Start/Done handshake.
// Optional feature macro: DIV_SIGNED_EN (two's complement operands, truncating division).
module seq_shift_sub_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero
);

  localparam int unsigned CNT_BITS = cnt_width(WIDTH);

  div_state_e            state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]      r_q, r_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic [WIDTH-1:0]      d_q, d_d;
  logic [WIDTH-1:0]      quotient_q, quotient_d;
  logic [WIDTH-1:0]      remainder_q, remainder_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;

  logic [WIDTH:0]        r_shift_c;
  logic [WIDTH-1:0]      diff_c;
  logic                  borrow_c;
  logic [WIDTH-1:0]      r_step_c;
  logic [WIDTH-1:0]      q_step_c;
  logic [WIDTH-1:0]      quot_fix_c;
  logic [WIDTH-1:0]      rem_fix_c;
  logic [WIDTH-1:0]      dividend_mag_c;
  logic [WIDTH-1:0]      divisor_mag_c;

`ifdef DIV_SIGNED_EN
  logic                  neg_q_q, neg_q_d;
  logic                  neg_r_q, neg_r_d;

  // Magnitudes feed the unsigned core; most-negative maps to 2^(WIDTH-1).
  always_comb begin
    dividend_mag_c = Dividend[WIDTH-1] ? (-Dividend) : Dividend;
    divisor_mag_c  = Divisor[WIDTH-1]  ? (-Divisor)  : Divisor;
  end

  // Sign fix-up applied as the final step result is loaded into the outputs.
  always_comb begin
    quot_fix_c = neg_q_q ? (-q_step_c) : q_step_c;
    rem_fix_c  = neg_r_q ? (-r_step_c) : r_step_c;
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    dividend_mag_c = Dividend;
    divisor_mag_c  = Divisor;
    quot_fix_c     = q_step_c;
    rem_fix_c      = r_step_c;
  end
`endif

  // One shift-subtract step: {R,Q} shifted left, trial subtract, restore on borrow.
  assign r_shift_c = {r_q, q_q[WIDTH-1]};

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_trial_sub (
    .r_shifted    (r_shift_c),
    .d            (d_q),
    .difference_c (diff_c),
    .borrow_c     (borrow_c)
  );

  assign r_step_c = borrow_c ? r_shift_c[WIDTH-1:0] : diff_c;
  assign q_step_c = {q_q[WIDTH-2:0], ~borrow_c};

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (Start) begin
          dbz_d = 1'b0;
          r_d   = '0;
          q_d   = dividend_mag_c;
          d_d   = divisor_mag_c;
          cnt_d = CNT_BITS'(WIDTH);
`ifdef DIV_SIGNED_EN
          neg_q_d = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
          neg_r_d = Dividend[WIDTH-1];
`endif
          if (Divisor == '0) begin
            state_d     = FIN;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = Dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        r_d   = r_step_c;
        q_d   = q_step_c;
        cnt_d = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) begin
          state_d     = FIN;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = quot_fix_c;
          remainder_d = rem_fix_c;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  // Result sign flags captured with the operands.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`endif

  assign Quotient    = quotient_q;
  assign Remainder   = remainder_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_seq_shift_sub_divider.sv
// Self-checking bench for seq_shift_sub_divider: directed cases plus random operands
// against an arithmetic reference model. Honours DIV_SIGNED_EN like the design.
module tb_seq_shift_sub_divider;

  localparam int unsigned W = 32;

  logic          Clock;
  logic          Reset;
  logic          Start;
  logic [W-1:0]  Dividend;
  logic [W-1:0]  Divisor;
  logic [W-1:0]  Quotient;
  logic [W-1:0]  Remainder;
  logic          Busy;
  logic          Done;
  logic          Div_By_Zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shift_sub_divider #(
    .WIDTH (W)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .Busy        (Busy),
    .Done        (Done),
    .Div_By_Zero (Div_By_Zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic division.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
`ifdef DIV_SIGNED_EN
    longint sa;
    longint sb;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // One division: optional stray Start while busy, optional Start in the Done cycle.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int glitch_at, input bit start_in_fin);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           lat;
    ref_div(a, b, eq, er, ez);
    @(negedge Clock);
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(posedge Clock);
    #1;
    Start    = 1'b0;
    Dividend = W'($urandom);
    Divisor  = W'($urandom);
    lat = 0;
    while (!Done && lat < int'(W) + 5) begin
      check_eq("busy_while_running", 64'(Busy), 64'd1);
      if (lat == glitch_at) begin
        @(negedge Clock);
        Start    = 1'b1;
        Dividend = W'(9);
        Divisor  = W'(3);
      end
      @(posedge Clock);
      #1;
      Start = 1'b0;
      lat++;
    end
    check_eq("latency", 64'(lat), (b == '0) ? 64'd0 : 64'(W));
    check_eq("done", 64'(Done), 64'd1);
    check_eq("busy_at_done", 64'(Busy), 64'd0);
    check_eq("quotient", 64'(Quotient), 64'(eq));
    check_eq("remainder", 64'(Remainder), 64'(er));
    check_eq("div_by_zero", 64'(Div_By_Zero), 64'(ez));
    if (start_in_fin) begin
      @(negedge Clock);
      Start    = 1'b1;
      Dividend = W'(1000);
      Divisor  = W'(3);
    end
    @(posedge Clock);
    #1;
    Start = 1'b0;
    check_eq("done_one_cycle", 64'(Done), 64'd0);
    check_eq("busy_after_done", 64'(Busy), 64'd0);
    check_eq("quotient_held", 64'(Quotient), 64'(eq));
    check_eq("remainder_held", 64'(Remainder), 64'(er));
  endtask

  initial begin
    int seen;
    int sel;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    Reset    = 1'b1;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_eq("reset_quotient", 64'(Quotient), 64'd0);
    check_eq("reset_remainder", 64'(Remainder), 64'd0);
    check_eq("reset_busy", 64'(Busy), 64'd0);
    check_eq("reset_done", 64'(Done), 64'd0);
    check_eq("reset_dbz", 64'(Div_By_Zero), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;

    do_div(W'(100), W'(7), -1, 1'b0);
    do_div('1, W'(1), -1, 1'b0);
    do_div(W'(3), W'(10), -1, 1'b0);
    do_div(W'(5), '0, -1, 1'b1);
    do_div(W'(100), W'(7), 9, 1'b1);
    do_div(W'(12345), '0, -1, 1'b0);
    do_div(W'(77), W'(77), -1, 1'b0);

    // Abort mid-operation with Reset; no Done may follow.
    @(negedge Clock);
    Start    = 1'b1;
    Dividend = W'(100);
    Divisor  = W'(7);
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (13) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check_eq("abort_quotient", 64'(Quotient), 64'd0);
    check_eq("abort_remainder", 64'(Remainder), 64'd0);
    check_eq("abort_busy", 64'(Busy), 64'd0);
    check_eq("abort_done", 64'(Done), 64'd0);
    check_eq("abort_dbz", 64'(Div_By_Zero), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock);
      #1;
      if (Done) seen++;
    end
    check_eq("abort_no_done", 64'(seen), 64'd0);
    do_div(W'(9), W'(3), -1, 1'b0);

`ifdef DIV_SIGNED_EN
    do_div(W'(-7), W'(2), -1, 1'b0);
    do_div(W'(7), W'(-2), -1, 1'b0);
    do_div(W'(-7), W'(-2), -1, 1'b0);
    do_div(W'(32'h8000_0000), W'(-1), -1, 1'b0);
    do_div(W'(-5), '0, -1, 1'b0);
`endif

    for (int n = 0; n < 24; n++) begin
      ra  = W'($urandom);
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 15));
        3:       rb = ra >> $urandom_range(0, 8);
        4:       rb = W'($urandom);
        default: rb = W'($urandom) >> $urandom_range(0, 31);
      endcase
      do_div(ra, rb, ((n % 5) == 0) ? int'($urandom_range(0, 20)) : -1, (n % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
